sat_block_avg: RTL and testbench
================================

SAT_BLOCK_AVG -- requirements
Module: sat_block_avg

Interface
REQ-001 Parameter: LOG2N, default 3, log2 of the block length N (samples per average); legal range 1..4.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset; one clock, sampled on rising clk edge.
REQ-004 Port: in_data  input  5  signed two's-complement sample, range -16..15, from the upstream saturating round stage.
REQ-005 Port: in_valid  input  1  in_data valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts a sample this cycle; transfer occurs when in_valid && in_ready.
REQ-007 Port: flush  input  1  discards the partial block in progress.
REQ-008 Port: out_data  output  5  signed block average, range -16..15.
REQ-009 Port: out_valid  output  1  out_data holds an unconsumed result.
REQ-010 Port: out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready.

Function
REQ-011 Accumulator SHALL be signed, width 5+LOG2N; it cannot overflow for any N legal samples.
REQ-012 Sample counter SHALL be LOG2N bits; it increments on each input transfer and wraps from N-1 to 0.
REQ-013 in_ready SHALL equal (!out_valid || out_ready); it is combinational, with no dependence on in_valid.
REQ-014 On an input transfer with count < N-1: acc <= acc + sign-extended in_data.
REQ-015 On an input transfer with count == N-1: the average SHALL be computed from acc + in_data per REQ-026/027; out_data is registered; out_valid=1 on the next cycle; acc and count clear in the same edge. Latency is 1 clk from the Nth sample to out_valid.
REQ-016 Average arithmetic SHALL be an arithmetic right shift by LOG2N of the full-width sum, with the rounding term per Configuration. Result SHALL be clamped to -16..15. Clamp is a guard only; it is unreachable for legal inputs.
REQ-017 out_valid && !out_ready: out_data and out_valid SHALL hold stable, and in_ready=0.
REQ-018 out_valid && out_ready without block completion in the same cycle: out_valid SHALL clear on the next edge.
REQ-019 Output handshake and Nth-sample transfer in the same cycle: out_data SHALL be replaced by the new average and out_valid SHALL stay 1. There is no bubble.
REQ-020 flush=1: acc and count SHALL clear and any in_data in that cycle is dropped, even if in_valid && in_ready. A pending out_data/out_valid SHALL be unaffected.
REQ-021 flush SHALL have priority over block completion in the same cycle; no output is produced.
REQ-022 States are ACCUM (count 0..N-1, out_valid=0) and ACCUM+HOLD (out_valid=1). Transitions follow REQ-015, REQ-018 and REQ-019.

Reset
REQ-023 rst SHALL force acc=0, count=0, out_valid=0 and out_data=0 on the next rising edge.
REQ-024 rst SHALL have priority over flush and over all transfers in the same cycle.
REQ-025 rst asserted mid-block or during HOLD SHALL discard the partial sum and the pending result; the first accepted sample after rst starts a new block.

Configuration
REQ-026 Macro SAT_BLOCK_AVG_ROUND_EN defined: round half-up, i.e. (sum + 2^(LOG2N-1)) >>> LOG2N.
REQ-027 Macro SAT_BLOCK_AVG_ROUND_EN undefined: floor, i.e. sum >>> LOG2N with no rounding term.
REQ-028 All other behaviour SHALL be identical in both builds.

Verification
REQ-029 LOG2N=3, out_ready=1, 8 samples of +15: out_data=15, out_valid high for exactly 1 cycle. Then 8 samples of -16: out_data=-16.
REQ-030 Rounding, samples {4,0,0,0,0,0,0,0} then {-4,0,0,0,0,0,0,0}: with ROUND_EN the outputs are 1 then 0; without ROUND_EN the outputs are 0 then -1.
REQ-031 Backpressure: block of eight 3s completes, out_ready=0 for 5 cycles. Required: out_data=3 held, in_ready=0 throughout. After out_ready=1, out_valid drops the next cycle.
REQ-032 Back-to-back: continuous in_valid with out_ready=1, blocks of 2s then 5s. Required: in_ready never deasserts; outputs are 2 then 5 with no idle cycle between the block-boundary results.
REQ-033 Flush mid-block: 3 samples of 7, flush 1 cycle, then 8 samples of -2. Required: a single output of -2.
REQ-034 Reset mid-block after 5 samples of 9: 8 samples of 1 then yield out_data=1. Reset during HOLD: out_valid=0 and out_data=0 on the next cycle.

Source files
------------

// File: rtl/sat_block_avg.sv
// Block averager: sums N = 2**LOG2N signed 5-bit samples and emits one clamped average per block.
// Define SAT_BLOCK_AVG_ROUND_EN for round-half-up averaging; otherwise the average is floored.
module sat_block_avg #(
  parameter int LOG2N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [4:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic signed [4:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int AW = 5 + LOG2N;
  localparam logic [LOG2N-1:0] LAST = '1;
  localparam logic signed [AW:0] MAXV = (AW+1)'(15);
  localparam logic signed [AW:0] MINV = (AW+1)'(-16);
`ifdef SAT_BLOCK_AVG_ROUND_EN
  localparam logic signed [AW:0] ROUND_TERM = (AW+1)'(2 ** (LOG2N - 1));
`endif

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t                state;
  state_t                state_next;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  sum;
  logic [LOG2N-1:0]      count;
  logic signed [AW:0]    sum_wide;
  logic signed [AW:0]    shifted;
  logic signed [4:0]     avg;
  logic                  take;
  logic                  complete;

  // A held result only blocks input when downstream is not taking it this cycle.
  assign in_ready  = (state == ACCUM) || out_ready;
  assign out_valid = (state == HOLD);
  assign take      = in_valid && in_ready && !flush;
  assign complete  = take && (count == LAST);
  assign sum       = acc + {{LOG2N{in_data[4]}}, in_data};

  always_comb begin
    sum_wide = {sum[AW-1], sum};
`ifdef SAT_BLOCK_AVG_ROUND_EN
    sum_wide = {sum[AW-1], sum} + ROUND_TERM;
`endif
    shifted = sum_wide >>> LOG2N;
    avg     = shifted[4:0];
    if (shifted > MAXV) begin
      avg = 5'sd15;
    end else if (shifted < MINV) begin
      avg = 5'sb10000;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM: begin
        if (complete) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!complete && out_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        acc   <= '0;
        count <= '0;
      end else if (take) begin
        if (complete) begin
          acc   <= '0;
          count <= '0;
        end else begin
          acc   <= sum;
          count <= count + 1'b1;
        end
      end
      if (complete) begin
        out_data <= avg;
      end
    end
  end

endmodule

// File: tb/tb_sat_block_avg.sv
// Randomized and directed scoreboard bench for sat_block_avg (LOG2N = 3).
// The expected averages come from a queue-based block model using plain integer arithmetic.
module tb_sat_block_avg;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [4:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic signed [4:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int blk[$];
  bit pending = 1'b0;
  bit fresh = 1'b1;
  int mdl_out = 0;

  always #5 clk = ~clk;

  sat_block_avg #(.LOG2N(LOG2N)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic int refAvg(input int samples[$]);
    int s;
    int q;
    s = 0;
    foreach (samples[i]) s += samples[i];
`ifdef SAT_BLOCK_AVG_ROUND_EN
    s += N / 2;
`endif
    q = s / N;
    if ((s % N) != 0 && s < 0) q -= 1;
    if (q > 15) q = 15;
    if (q < -16) q = -16;
    return q;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every output handshake consumes the oldest expected average.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0d expected none at %0t", out_data, $time);
        end else begin
          checkOutput("out_data_sb", int'(out_data), exp_q.pop_front());
        end
      end
    end
  end

  // Drives one cycle of inputs, checks handshake outputs, then advances the block model.
  task automatic applyStimulus(input bit v, input int d, input bit f, input bit r, input bit o);
    bit ir_exp;
    in_valid  = v;
    in_data   = d[4:0];
    flush     = f;
    rst       = r;
    out_ready = o;
    @(negedge clk);
    #1;
    ir_exp = !pending || o;
    checkOutput("in_ready", int'(in_ready), int'(ir_exp));
    checkOutput("out_valid", int'(out_valid), int'(pending));
    if (pending || fresh) checkOutput("out_data_hold", int'(out_data), mdl_out);
    if (r) begin
      blk.delete();
      exp_q.delete();
      pending = 1'b0;
      fresh   = 1'b1;
      mdl_out = 0;
    end else if (f) begin
      blk.delete();
      pending = pending && !o;
    end else if (v && ir_exp) begin
      blk.push_back(d);
      if (blk.size() == N) begin
        mdl_out = refAvg(blk);
        exp_q.push_back(mdl_out);
        blk.delete();
        pending = 1'b1;
        fresh   = 1'b0;
      end else begin
        pending = pending && !o;
      end
    end else begin
      pending = pending && !o;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feedBlock(input int val, input int cnt, input bit o);
    for (int i = 0; i < cnt; i++) applyStimulus(1'b1, val, 1'b0, 1'b0, o);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);

    $display("[TB] saturation extremes");
    feedBlock(15, N, 1'b1);
    feedBlock(-16, N, 1'b1);
    idle(3);

    $display("[TB] rounding");
    applyStimulus(1'b1, 4, 1'b0, 1'b0, 1'b1);
    feedBlock(0, N - 1, 1'b1);
    applyStimulus(1'b1, -4, 1'b0, 1'b0, 1'b1);
    feedBlock(0, N - 1, 1'b1);
    idle(2);

    $display("[TB] backpressure");
    feedBlock(3, N, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(3);

    $display("[TB] back-to-back");
    feedBlock(2, N, 1'b1);
    feedBlock(5, N, 1'b1);
    idle(2);

    $display("[TB] flush mid-block");
    feedBlock(7, 3, 1'b1);
    applyStimulus(1'b1, 7, 1'b1, 1'b0, 1'b1);
    feedBlock(-2, N, 1'b1);
    idle(2);

    $display("[TB] reset mid-block and during hold");
    feedBlock(9, 5, 1'b1);
    applyStimulus(1'b1, 9, 1'b0, 1'b1, 1'b1);
    feedBlock(1, N, 1'b1);
    idle(2);
    feedBlock(6, N, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4, 1'b1, 1'b1, 1'b0);
    idle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit f;
      bit r;
      bit o;
      int d;
      v = ($urandom_range(0, 3) != 0);
      d = int'($urandom_range(0, 31)) - 16;
      f = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 63) == 0);
      o = r ? 1'b0 : ($urandom_range(0, 3) != 0);
      applyStimulus(v, d, f, r, o);
    end

    for (int i = 0; i < 40 && (pending || exp_q.size() != 0); i++) idle(1);
    checkOutput("drain_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
